// File: rtl/ad9361_init_seq_if.sv
// ---------------------------------------------------------------------------
// ad9361_init_seq_if
//   Request/response bundle between the AD9361 bring-up sequencer and the
//   AD9361 SPI register driver.
//
//   Signals
//     spi_addr      10  register address            (sequencer -> driver)
//     spi_wdata      8  write data                  (sequencer -> driver)
//     spi_wr_rdn     1  1 = write, 0 = read         (sequencer -> driver)
//     spi_en         1  level request               (sequencer -> driver)
//     spi_rdata      8  read data                   (driver -> sequencer)
//     spi_rdata_en   1  read data strobe            (driver -> sequencer)
//     spi_busy       1  frame in progress           (driver -> sequencer)
//
//   Modports
//     master  the sequencer side (drives the request)
//     slave   the SPI driver side (answers the request)
// ---------------------------------------------------------------------------
interface ad9361_init_seq_if;
    logic [9:0] spi_addr;
    logic [7:0] spi_wdata;
    logic       spi_wr_rdn;
    logic       spi_en;
    logic [7:0] spi_rdata;
    logic       spi_rdata_en;
    logic       spi_busy;

    modport master (
        output spi_addr,
        output spi_wdata,
        output spi_wr_rdn,
        output spi_en,
        input  spi_rdata,
        input  spi_rdata_en,
        input  spi_busy
    );

    modport slave (
        input  spi_addr,
        input  spi_wdata,
        input  spi_wr_rdn,
        input  spi_en,
        output spi_rdata,
        output spi_rdata_en,
        output spi_busy
    );
endinterface

// File: rtl/ad9361_init_seq.sv
// ---------------------------------------------------------------------------
// ad9361_init_seq
//   Table-driven AD9361 bring-up sequencer. Walks a command ROM from index 0
//   and executes each 32-bit command through the AD9361 SPI register driver:
//   register writes, register reads, masked polls and timed delays.
//
//   Command word: op[31:30] addr[29:20] data[19:12] mask[11:4] rsvd[3:0]
//     op 00 WRITE  addr <= data
//     op 01 READ   addr -> rd_data, rd_vld pulse
//     op 10 POLL   read addr until (rdata & mask) == (data & mask)
//     op 11 DELAY  {addr,data} * DLY_TICK cycles; a count of 0 is END
//
//   Parameters
//     ROM_AW    ROM address width (table depth 2**ROM_AW)
//     DLY_TICK  sys_clk cycles per DELAY count unit
//     POLL_MAX  POLL attempts before error (timeout build only)
//
//   Ports
//     sys_clk, sys_rst_n   clock, synchronous active-low reset
//     start                1-cycle pulse, runs the table from index 0
//     busy                 high from start accept until done/error
//     done                 1-cycle pulse when the table end is reached
//     error                sticky until next start, POLL timed out
//     cmd_idx              index of the command executing / failed
//     rd_data, rd_vld      last READ/POLL result, pulse on READ update
//     rom_addr, rom_data   command ROM (data valid 1 cycle after address)
//     spi                  SPI driver request side (master modport)
//
//   Build option
//     AD9361_SEQ_TIMEOUT_EN  when defined, a POLL gives up after POLL_MAX
//                            mismatching reads and the sequencer raises
//                            error. When undefined, a POLL retries forever
//                            and error is tied low.
// ---------------------------------------------------------------------------
module ad9361_init_seq #(
    parameter int ROM_AW   = 6,
    parameter int DLY_TICK = 20,
    parameter int POLL_MAX = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] cmd_idx,
    output logic [7:0]        rd_data,
    output logic              rd_vld,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    ad9361_init_seq_if.master spi
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_DELAY = 2'b11;

    localparam int                TICK_W     = (DLY_TICK > 1) ? $clog2(DLY_TICK) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DLY_TICK - 1);
    // The cycle that loads the delay counter is counted as the first tick
    // cycle, so the whole wait including that cycle is count*DLY_TICK.
    localparam logic [TICK_W-1:0] TICK_FIRST = (DLY_TICK > 1) ? TICK_W'(1) : '0;
    localparam logic [ROM_AW-1:0] IDX_LAST   = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SPI_REQ,
        S_SPI_ACK,
        S_SPI_WAIT,
        S_CHECK,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;

    logic [1:0]        cmd_op;
    logic [7:0]        cmd_mask;

    logic [9:0]        spi_addr_r;
    logic [7:0]        spi_wdata_r;
    logic              spi_wr_rdn_r;
    logic              spi_en_r;

    logic [7:0]        cap_data;
    logic              cap_vld;

    logic [17:0]       dly_units;
    logic [TICK_W-1:0] dly_tick;
    logic              dly_retry;

    logic              poll_match;

`ifdef AD9361_SEQ_TIMEOUT_EN
    localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);
    logic [7:0]        poll_cnt;
    logic              error_r;

    assign error = error_r;
`else
    logic              unused_cfg;

    assign error      = 1'b0;
    assign unused_cfg = (POLL_MAX > 0);
`endif

    logic              unused_rsvd;
    assign unused_rsvd = ^rom_data[3:0];

    assign spi.spi_addr   = spi_addr_r;
    assign spi.spi_wdata  = spi_wdata_r;
    assign spi.spi_wr_rdn = spi_wr_rdn_r;
    assign spi.spi_en     = spi_en_r;

    // Only the bits selected by the mask take part in the POLL comparison.
    assign poll_match = ((cap_data ^ spi_wdata_r) & cmd_mask) == 8'h00;

    // Sequencer state machine. All outputs are registered here; done and
    // rd_vld default low every cycle so they form single-cycle pulses.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_vld       <= 1'b0;
            rd_data      <= 8'h00;
            cmd_idx      <= '0;
            rom_addr     <= '0;
            cmd_op       <= OP_WRITE;
            cmd_mask     <= 8'h00;
            spi_addr_r   <= 10'h000;
            spi_wdata_r  <= 8'h00;
            spi_wr_rdn_r <= 1'b1;
            spi_en_r     <= 1'b0;
            cap_data     <= 8'h00;
            cap_vld      <= 1'b0;
            dly_units    <= 18'd0;
            dly_tick     <= '0;
            dly_retry    <= 1'b0;
`ifdef AD9361_SEQ_TIMEOUT_EN
            poll_cnt     <= 8'd0;
            error_r      <= 1'b0;
`endif
        end else begin
            done   <= 1'b0;
            rd_vld <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        cmd_idx  <= '0;
                        rom_addr <= '0;
`ifdef AD9361_SEQ_TIMEOUT_EN
                        error_r  <= 1'b0;
`endif
                        state    <= S_FETCH;
                    end
                end

                // The ROM address was set on the way in; this cycle lets the
                // synchronous ROM present the word for DECODE.
                S_FETCH: begin
                    state <= S_DECODE;
                end

                S_DECODE: begin
                    cmd_op   <= rom_data[31:30];
                    cmd_mask <= rom_data[11:4];
                    case (rom_data[31:30])
                        OP_DELAY: begin
                            if (rom_data[29:12] == 18'd0) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_DONE;
                            end else begin
                                dly_units <= rom_data[29:12];
                                dly_tick  <= TICK_FIRST;
                                dly_retry <= 1'b0;
                                state     <= S_DELAY;
                            end
                        end
                        default: begin
                            spi_addr_r   <= rom_data[29:20];
                            spi_wdata_r  <= rom_data[19:12];
                            spi_wr_rdn_r <= (rom_data[31:30] == OP_WRITE);
                            spi_en_r     <= 1'b1;
                            cap_vld      <= 1'b0;
`ifdef AD9361_SEQ_TIMEOUT_EN
                            poll_cnt     <= 8'd0;
`endif
                            state        <= S_SPI_REQ;
                        end
                    endcase
                end

                // Hold the request until the driver shows it has taken it;
                // the request drops on the same edge busy is seen.
                S_SPI_REQ: begin
                    if (spi.spi_busy) begin
                        spi_en_r <= 1'b0;
                        state    <= S_SPI_ACK;
                    end
                end

                S_SPI_ACK: begin
                    if (spi.spi_rdata_en && !cap_vld) begin
                        cap_data <= spi.spi_rdata;
                        cap_vld  <= 1'b1;
                    end
                    state <= S_SPI_WAIT;
                end

                // Reads finish only once both the data strobe has been seen
                // and the driver has dropped busy, whichever comes last.
                S_SPI_WAIT: begin
                    if (spi.spi_rdata_en && !cap_vld) begin
                        cap_data <= spi.spi_rdata;
                        cap_vld  <= 1'b1;
                    end
                    if (!spi.spi_busy && (spi_wr_rdn_r || cap_vld || spi.spi_rdata_en)) begin
                        state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    case (cmd_op)
                        OP_READ: begin
                            rd_data <= cap_data;
                            rd_vld  <= 1'b1;
                            state   <= S_NEXT;
                        end
                        OP_POLL: begin
                            rd_data <= cap_data;
                            if (poll_match) begin
                                state <= S_NEXT;
                            end
`ifdef AD9361_SEQ_TIMEOUT_EN
                            else if (poll_cnt == POLL_LAST) begin
                                error_r <= 1'b1;
                                busy    <= 1'b0;
                                state   <= S_ERR;
                            end
`endif
                            else begin
`ifdef AD9361_SEQ_TIMEOUT_EN
                                poll_cnt  <= poll_cnt + 8'd1;
`endif
                                dly_units <= 18'd1;
                                dly_tick  <= TICK_FIRST;
                                dly_retry <= 1'b1;
                                state     <= S_DELAY;
                            end
                        end
                        default: begin
                            state <= S_NEXT;
                        end
                    endcase
                end

                // Count units of DLY_TICK cycles. A POLL retry returns
                // straight to the SPI request instead of the next command.
                S_DELAY: begin
                    if (dly_tick == TICK_LAST) begin
                        dly_tick <= '0;
                        if (dly_units == 18'd1) begin
                            if (dly_retry) begin
                                spi_en_r <= 1'b1;
                                cap_vld  <= 1'b0;
                                state    <= S_SPI_REQ;
                            end else begin
                                state <= S_NEXT;
                            end
                        end else begin
                            dly_units <= dly_units - 18'd1;
                        end
                    end else begin
                        dly_tick <= dly_tick + TICK_W'(1);
                    end
                end

                // Running off the last table entry ends the run; the index
                // never wraps back to 0.
                S_NEXT: begin
                    if (cmd_idx == IDX_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        cmd_idx  <= cmd_idx + 1'b1;
                        rom_addr <= cmd_idx + 1'b1;
                        state    <= S_FETCH;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                S_ERR: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad9361_init_seq.sv
// ---------------------------------------------------------------------------
// tb_ad9361_init_seq
//   Self-checking bench for ad9361_init_seq. A synchronous ROM model feeds
//   the command table, a behavioural SPI driver answers requests, and a
//   scoreboard compares every observed event (SPI frame start, rd_vld pulse,
//   done pulse, error rise) against the expectations queued by each test.
//   The POLL timeout test runs only when AD9361_SEQ_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_ad9361_init_seq;

    localparam int ROM_AW   = 6;
    localparam int DLY_TICK = 20;
    localparam int POLL_MAX = 4;

    localparam int EV_FRAME = 0;
    localparam int EV_RDVLD = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_ERR   = 3;

    typedef struct {
        int          kind;
        logic [31:0] value;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  resp_q[$];
    int          frame_cyc[$];

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              start     = 1'b0;
    logic              busy;
    logic              done;
    logic              error;
    logic              rd_vld;
    logic [ROM_AW-1:0] cmd_idx;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rd_data;
    logic [31:0]       rom_data;
    logic [31:0]       rom [64];

    int   total       = 0;
    int   bad         = 0;
    int   cyc         = 0;
    int   done_cyc    = 0;
    int   start_cyc   = 0;
    int   en_rise_cnt = 0;
    logic drv_enable  = 1'b1;
    logic prev_busy   = 1'b0;
    logic prev_err    = 1'b0;
    logic prev_en     = 1'b0;

    ad9361_init_seq_if spi_if ();

    ad9361_init_seq #(
        .ROM_AW   (ROM_AW),
        .DLY_TICK (DLY_TICK),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cmd_idx   (cmd_idx),
        .rd_data   (rd_data),
        .rd_vld    (rd_vld),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .spi       (spi_if)
    );

    // Free-running clock and a cycle counter used for latency measurements.
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Synchronous command ROM: data appears one cycle after the address.
    always @(posedge sys_clk) rom_data <= rom[rom_addr];

    function automatic logic [31:0] cmd_wr(input logic [9:0] a, input logic [7:0] d);
        return {2'b00, a, d, 8'h00, 4'h0};
    endfunction

    function automatic logic [31:0] cmd_rd(input logic [9:0] a);
        return {2'b01, a, 8'h00, 8'h00, 4'h0};
    endfunction

    function automatic logic [31:0] cmd_poll(input logic [9:0] a, input logic [7:0] d, input logic [7:0] m);
        return {2'b10, a, d, m, 4'h0};
    endfunction

    function automatic logic [31:0] cmd_dly(input logic [17:0] c);
        return {2'b11, c, 12'h000};
    endfunction

    function automatic logic [31:0] ev_frame(input logic wr, input logic [9:0] a, input logic [7:0] d);
        return {8'h00, wr, 5'b00000, a, d};
    endfunction

    function automatic logic [31:0] ev_stat(input logic b, input logic e, input logic [ROM_AW-1:0] idx);
        return {24'h0, b, e, idx};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] value, input string name);
        exp_t e;
        e.kind  = kind;
        e.value = value;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] value);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_event actual=%0d:%h expected=none", kind, value);
        end else begin
            e = exp_q.pop_front();
            checkOutput(e.name, {32'(kind), value}, {32'(e.kind), e.value});
        end
    endtask

    // Pulse start for one clock and remember the cycle it was accepted on.
    task automatic applyStimulus();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    // Wait (bounded) for the run to finish, then make sure every queued
    // expectation has been consumed.
    task automatic wait_end(input int max_cyc, input string name);
        int n = 0;
        @(negedge sys_clk);
        while (busy && n < max_cyc) begin
            @(negedge sys_clk);
            n++;
        end
        checkOutput({name, "_finished"}, 64'(busy), 64'(0));
        repeat (3) @(negedge sys_clk);
        checkOutput({name, "_drained"}, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    // Behavioural SPI driver: accepts a level request, holds busy for a
    // fixed frame length and strobes read data near the end of read frames.
    initial begin : spi_driver
        logic is_read;
        spi_if.spi_busy     = 1'b0;
        spi_if.spi_rdata_en = 1'b0;
        spi_if.spi_rdata    = 8'h00;
        forever begin
            @(posedge sys_clk); #1;
            if (drv_enable && sys_rst_n && spi_if.spi_en) begin
                is_read = !spi_if.spi_wr_rdn;
                @(posedge sys_clk); #1;
                spi_if.spi_busy = 1'b1;
                repeat (5) begin @(posedge sys_clk); #1; end
                if (is_read) begin
                    spi_if.spi_rdata    = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
                    spi_if.spi_rdata_en = 1'b1;
                    @(posedge sys_clk); #1;
                    spi_if.spi_rdata_en = 1'b0;
                end
                repeat (2) begin @(posedge sys_clk); #1; end
                spi_if.spi_busy = 1'b0;
            end
        end
    end

    // Monitor: turns DUT activity into events and hands them to the
    // scoreboard, sampling on the falling edge away from the active edge.
    initial begin : monitor
        forever begin
            @(negedge sys_clk);
            if (spi_if.spi_en && !prev_en) en_rise_cnt++;
            if (spi_if.spi_busy && !prev_busy) begin
                frame_cyc.push_back(cyc);
                observe(EV_FRAME, ev_frame(spi_if.spi_wr_rdn, spi_if.spi_addr, spi_if.spi_wdata));
            end
            if (rd_vld) observe(EV_RDVLD, {24'h0, rd_data});
            if (done) begin
                done_cyc = cyc;
                observe(EV_DONE, ev_stat(busy, error, cmd_idx));
            end
            if (error && !prev_err) observe(EV_ERR, ev_stat(busy, error, cmd_idx));
            prev_en   = spi_if.spi_en;
            prev_busy = spi_if.spi_busy;
            prev_err  = error;
        end
    end

    // Single write followed by END: one write frame, then done at index 1.
    task automatic run_t1(input string name);
        rom[0] = cmd_wr(10'h3DF, 8'h01);
        rom[1] = cmd_dly(18'd0);
        expect_ev(EV_FRAME, 32'h0083DF01, {name, "_frame"});
        expect_ev(EV_DONE, ev_stat(1'b0, 1'b0, 6'd1), {name, "_done"});
        applyStimulus();
        wait_end(500, name);
    endtask

    initial begin : main
        int n;
        int gap;
        for (int i = 0; i < 64; i++) rom[i] = cmd_dly(18'd0);

        // Reset values.
        repeat (4) @(negedge sys_clk);
        checkOutput("rst_ctrl", {60'h0, busy, done, error, rd_vld}, 64'h0);
        checkOutput("rst_idx", {52'h0, cmd_idx, rom_addr}, 64'h0);
        checkOutput("rst_rd_data", 64'(rd_data), 64'h0);
        checkOutput("rst_spi", {44'h0, spi_if.spi_en, spi_if.spi_wr_rdn, spi_if.spi_addr, spi_if.spi_wdata},
                    {44'h0, 1'b0, 1'b1, 10'h000, 8'h00});
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        $display("[TB] T1 single write");
        run_t1("t1");

        $display("[TB] T2 read");
        rom[0] = cmd_rd(10'h037);
        rom[1] = cmd_dly(18'd0);
        resp_q.push_back(8'hA5);
        expect_ev(EV_FRAME, 32'h00003700, "t2_frame");
        expect_ev(EV_RDVLD, 32'h000000A5, "t2_rd_vld");
        expect_ev(EV_DONE, ev_stat(1'b0, 1'b0, 6'd1), "t2_done");
        applyStimulus();
        wait_end(500, "t2");

        $display("[TB] T3 poll with retries");
        rom[0] = cmd_poll(10'h247, 8'h02, 8'h02);
        rom[1] = cmd_wr(10'h010, 8'h55);
        rom[2] = cmd_dly(18'd0);
        resp_q.delete();
        resp_q.push_back(8'h00);
        resp_q.push_back(8'h00);
        resp_q.push_back(8'h02);
        frame_cyc.delete();
        for (int i = 0; i < 3; i++) expect_ev(EV_FRAME, 32'h00024702, "t3_poll_frame");
        expect_ev(EV_FRAME, 32'h00801055, "t3_next_frame");
        expect_ev(EV_DONE, ev_stat(1'b0, 1'b0, 6'd2), "t3_done");
        applyStimulus();
        wait_end(1000, "t3");
        checkOutput("t3_frame_count", 64'(frame_cyc.size()), 64'd4);
        if (frame_cyc.size() >= 3) begin
            for (int i = 1; i < 3; i++) begin
                gap = frame_cyc[i] - frame_cyc[i-1];
                checkOutput("t3_retry_gap", 64'((gap >= DLY_TICK) && (gap <= DLY_TICK + 20)), 64'd1);
            end
        end
        checkOutput("t3_rd_data", 64'(rd_data), 64'h02);

        $display("[TB] T5 delay then END");
        rom[0] = cmd_dly(18'd5);
        rom[1] = cmd_dly(18'd0);
        en_rise_cnt = 0;
        expect_ev(EV_DONE, ev_stat(1'b0, 1'b0, 6'd1), "t5_done");
        applyStimulus();
        wait_end(500, "t5");
        // DELAY is entered two cycles (FETCH, DECODE) after start is taken.
        gap = done_cyc - (start_cyc + 2);
        checkOutput("t5_latency", 64'((gap >= 97) && (gap <= 103)), 64'd1);
        checkOutput("t5_no_spi_en", 64'(en_rise_cnt), 64'd0);

        $display("[TB] T7 full table, implicit end, start ignored while busy");
        for (int i = 0; i < 64; i++) begin
            rom[i] = cmd_wr(10'(i), 8'(i) ^ 8'h5A);
            expect_ev(EV_FRAME, ev_frame(1'b1, 10'(i), 8'(i) ^ 8'h5A), "t7_frame");
        end
        expect_ev(EV_DONE, ev_stat(1'b0, 1'b0, 6'd63), "t7_done");
        applyStimulus();
        repeat (40) @(negedge sys_clk);
        applyStimulus();
        wait_end(3000, "t7");

`ifdef AD9361_SEQ_TIMEOUT_EN
        $display("[TB] T4 poll timeout");
        rom[0] = cmd_poll(10'h100, 8'h80, 8'h80);
        rom[1] = cmd_dly(18'd0);
        resp_q.delete();
        for (int i = 0; i < POLL_MAX; i++) expect_ev(EV_FRAME, 32'h00010080, "t4_poll_frame");
        expect_ev(EV_ERR, ev_stat(1'b0, 1'b1, 6'd0), "t4_error");
        applyStimulus();
        wait_end(2000, "t4");
        checkOutput("t4_error_sticky", 64'(error), 64'd1);
`endif

        $display("[TB] T6 reset during request");
        rom[0] = cmd_wr(10'h3DF, 8'h01);
        rom[1] = cmd_dly(18'd0);
        drv_enable = 1'b0;
        applyStimulus();
        n = 0;
        while (!spi_if.spi_en && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        checkOutput("t6_spi_en_raised", 64'(spi_if.spi_en), 64'd1);
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        checkOutput("t6_spi_en_dropped", 64'(spi_if.spi_en), 64'd0);
        checkOutput("t6_busy_dropped", 64'(busy), 64'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n  = 1'b1;
        drv_enable = 1'b1;
        repeat (5) @(negedge sys_clk);
        checkOutput("t6_no_restart", {62'h0, busy, spi_if.spi_en}, 64'h0);
        checkOutput("t6_error_clear", 64'(error), 64'd0);
        run_t1("t6_rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall watchdog so the bench always terminates.
    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
